// File: rtl/sram_loader_pkg.sv
// Shared definitions for the SRAM image loader.
//   LOADER_MAGIC / LOADER_ACK / LOADER_NACK : frame start byte and response codes
//   state_t                                 : loader FSM states
//   resp_byte()                             : response code for a given error flag
package sram_loader_pkg;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;
  localparam logic [7:0] LOADER_ACK   = 8'h5A;
  localparam logic [7:0] LOADER_NACK  = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    WR,
    CSUM,
    RESP
  } state_t;

  function automatic logic [7:0] resp_byte(input logic err);
    return err ? LOADER_NACK : LOADER_ACK;
  endfunction

endpackage

// File: rtl/sram_image_loader.sv
// Runtime SRAM image loader.
// Parses frames  A5 | addr[31:0] LE | len[31:0] LE | payload | csum  from an RX
// byte stream, packs payload bytes into byte-strobed 64-bit SRAM writes and
// answers ACK (0x5A) or NACK (0xEE) on a TX byte stream.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_rx_valid/i_rx_data/o_rx_ready    RX byte stream
//   o_tx_valid/o_tx_data/i_tx_ready    TX response byte
//   o_wr_valid/o_wr_addr/o_wr_data/o_wr_strob/i_wr_ready   SRAM write port
//   o_busy   high outside IDLE
//   o_done   one-cycle pulse when the response byte is taken
//   o_err    sticky checksum/range/timeout error, cleared by the next magic byte
// Every output is driven straight from a register.
module sram_image_loader
  import sram_loader_pkg::*;
#(
  parameter int abits       = 18,
  parameter int timeout_cyc = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_rx_ready,
  output logic             o_tx_valid,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_ready,
  output logic             o_wr_valid,
  output logic [abits-1:0] o_wr_addr,
  output logic [63:0]      o_wr_data,
  output logic [7:0]       o_wr_strob,
  input  logic             i_wr_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int               TW       = $clog2(timeout_cyc + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(timeout_cyc - 1);
  localparam logic [32:0]      WINDOW   = 33'd1 << abits;

  state_t state_reg, state_next;

  // ptr holds the address while it is being received and then walks through
  // the payload; len holds the length and then counts the bytes still due.
  logic [1:0]       hdr_idx_reg, hdr_idx_next;
  logic [31:0]      ptr_reg, ptr_next;
  logic [31:0]      len_reg, len_next;
  logic [63:0]      word_reg, word_next;
  logic [7:0]       strob_reg, strob_next;
  logic [7:0]       csum_reg, csum_next;
  logic             range_err_reg, range_err_next;
  logic             err_reg, err_next;
  logic [TW-1:0]    tmo_reg, tmo_next;

  logic             rx_ready_reg, rx_ready_next;
  logic             tx_valid_reg, tx_valid_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             wr_valid_reg, wr_valid_next;
  logic [abits-1:0] wr_addr_reg, wr_addr_next;
  logic [63:0]      wr_data_reg, wr_data_next;
  logic [7:0]       wr_strob_reg, wr_strob_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             rx_accept;
  logic             counting;
  logic             timeout;
  logic [2:0]       lane;
  logic             last_byte;
  logic [31:0]      len_full;
  logic [32:0]      end_sum;
  logic             range_bad;
  logic             csum_bad;
  logic [63:0]      word_merge;
  logic [7:0]       strob_merge;

  assign rx_accept = i_rx_valid & rx_ready_reg;
  assign counting  = (state_reg == ADDR) || (state_reg == LEN) ||
                     (state_reg == DATA) || (state_reg == CSUM);
  assign lane      = ptr_reg[2:0];
  assign last_byte = (len_reg == 32'd1);
  assign csum_bad  = (i_rx_data != csum_reg);

  // Range check on the final length byte: 33-bit sum so a huge length
  // cannot wrap back into the window.
  assign len_full  = {i_rx_data, len_reg[31:8]};
  assign end_sum   = {1'b0, ptr_reg} + {1'b0, len_full};
  assign range_bad = (end_sum > WINDOW) || ((ptr_reg >> abits) != 32'd0);

  // Merge the incoming byte into the lane selected by the low pointer bits.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign word_merge[gi*8 +: 8] = (lane == 3'(gi)) ? i_rx_data : word_reg[gi*8 +: 8];
      assign strob_merge[gi]       = (lane == 3'(gi)) | strob_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    hdr_idx_next   = hdr_idx_reg;
    ptr_next       = ptr_reg;
    len_next       = len_reg;
    word_next      = word_reg;
    strob_next     = strob_reg;
    csum_next      = csum_reg;
    range_err_next = range_err_reg;
    err_next       = err_reg;
    tmo_next       = '0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    wr_strob_next  = wr_strob_reg;
    tx_data_next   = tx_data_reg;
    timeout        = 1'b0;

    // An accepted byte always restarts the idle counter, even in the cycle
    // the counter would otherwise expire.
    if (counting && !rx_accept) begin
      if (tmo_reg == TMO_LAST) timeout = 1'b1;
      else                     tmo_next = tmo_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (rx_accept && (i_rx_data == LOADER_MAGIC)) begin
          state_next     = ADDR;
          hdr_idx_next   = 2'd0;
          ptr_next       = '0;
          len_next       = '0;
          word_next      = '0;
          strob_next     = '0;
          csum_next      = '0;
          range_err_next = 1'b0;
          err_next       = 1'b0;
        end
      end
      ADDR: begin
        if (rx_accept) begin
          ptr_next     = {i_rx_data, ptr_reg[31:8]};
          hdr_idx_next = hdr_idx_reg + 2'd1;
          if (hdr_idx_reg == 2'd3) state_next = LEN;
        end
      end
      LEN: begin
        if (rx_accept) begin
          len_next     = len_full;
          hdr_idx_next = hdr_idx_reg + 2'd1;
          if (hdr_idx_reg == 2'd3) begin
            if (range_bad) begin
              range_err_next = 1'b1;
              err_next       = 1'b1;
            end
            state_next = (len_full == 32'd0) ? CSUM : DATA;
          end
        end
      end
      DATA: begin
        if (rx_accept) begin
          ptr_next  = ptr_reg + 32'd1;
          len_next  = len_reg - 32'd1;
          csum_next = csum_reg + i_rx_data;
          if (range_err_reg) begin
            // Out-of-window frame: swallow the payload without writing.
            if (last_byte) state_next = CSUM;
          end else if ((lane == 3'd7) || last_byte) begin
            wr_addr_next  = {ptr_reg[abits-1:3], 3'b000};
            wr_data_next  = word_merge;
            wr_strob_next = strob_merge;
            word_next     = '0;
            strob_next    = '0;
            state_next    = WR;
          end else begin
            word_next  = word_merge;
            strob_next = strob_merge;
          end
        end
      end
      WR: begin
        if (wr_valid_reg && i_wr_ready)
          state_next = (len_reg == 32'd0) ? CSUM : DATA;
      end
      CSUM: begin
        if (rx_accept) begin
          if (csum_bad) err_next = 1'b1;
          tx_data_next = resp_byte(err_reg | csum_bad);
          state_next   = RESP;
        end
      end
      RESP: begin
        if (tx_valid_reg && i_tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort: the partially assembled word is discarded and no response sent.
    if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
      word_next  = '0;
      strob_next = '0;
    end
  end

  // Output handshakes are registered from the next state so they line up
  // with the state they describe without any input-to-output path.
  assign rx_ready_next = (state_next != WR) && (state_next != RESP);
  assign wr_valid_next = (state_next == WR);
  assign tx_valid_next = (state_next == RESP);
  assign busy_next     = (state_next != IDLE);
  assign done_next     = (state_reg == RESP) && tx_valid_reg && i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      hdr_idx_reg   <= '0;
      ptr_reg       <= '0;
      len_reg       <= '0;
      word_reg      <= '0;
      strob_reg     <= '0;
      csum_reg      <= '0;
      range_err_reg <= 1'b0;
      err_reg       <= 1'b0;
      tmo_reg       <= '0;
      rx_ready_reg  <= 1'b0;
      tx_valid_reg  <= 1'b0;
      tx_data_reg   <= '0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_strob_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hdr_idx_reg   <= hdr_idx_next;
      ptr_reg       <= ptr_next;
      len_reg       <= len_next;
      word_reg      <= word_next;
      strob_reg     <= strob_next;
      csum_reg      <= csum_next;
      range_err_reg <= range_err_next;
      err_reg       <= err_next;
      tmo_reg       <= tmo_next;
      rx_ready_reg  <= rx_ready_next;
      tx_valid_reg  <= tx_valid_next;
      tx_data_reg   <= tx_data_next;
      wr_valid_reg  <= wr_valid_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_strob_reg  <= wr_strob_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign o_rx_ready = rx_ready_reg;
  assign o_tx_valid = tx_valid_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_wr_valid = wr_valid_reg;
  assign o_wr_addr  = wr_addr_reg;
  assign o_wr_data  = wr_data_reg;
  assign o_wr_strob = wr_strob_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_err      = err_reg;

endmodule
